line_window_feeder: RTL and testbench
=====================================

Name: line_window_feeder

Overview:
- Parametrised streaming front end for the edge-detection filter chain (median, Gaussian, Sobel, non-max, hysteresis).
- Accepts a raster pixel stream and emits one vertical K-pixel column per beat. Each downstream filter shifts these columns into its KxK kernel.
- Generalises the fixed 20x20, 3/5-row feeding scheme with:
  - configurable image size, pixel width and kernel size;
  - runtime border mode: valid-only, zero-pad or replicate;
  - valid/ready handshakes on both sides.

Parameters:
- IMG_W, 20, image width in pixels (>= K)
- IMG_H, 20, image height in rows (>= K)
- BIT_LENGTH, 5, pixel width
- K, 3, kernel size. Legal values are 3 and 5. P = (K-1)/2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  frame start pulse. Accepted only in IDLE.
- mode  in  2  border mode, latched on start: 0 valid-only, 1 zero-pad, 2 replicate, 3 treated as replicate
- in_pixel  in  BIT_LENGTH  raster-order input pixel
- in_valid  in  1  in_pixel valid
- in_ready  out  1  feeder accepts in_pixel this cycle
- out_col  out  K*BIT_LENGTH  window column; element i at [i*BIT_LENGTH +: BIT_LENGTH] is image row r-P+i
- out_valid  out  1  out_col valid
- out_ready  in  1  downstream accepts out_col
- out_first  out  1  first beat of an output row (qualified by out_valid)
- out_last  out  1  last beat of an output row
- frame_done  out  1  one-cycle pulse after the final beat is accepted
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_first=0, out_last=0, frame_done=0, busy=0, state=IDLE, all counters 0. Line-buffer contents are not cleared.
- Storage: K row buffers of IMG_W x BIT_LENGTH, used as a rotating ring. Row y lives in buffer y mod K.
- Counters: in_col, in_row, out_col, out_row, each $clog2-sized. out_col is signed-capable so it can reach -P.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- States:
  - IDLE: start -> FILL (latches mode, clears counters). start is ignored in any other state.
  - FILL: in_ready=1. Accepts input rows 0..F-1, where F=P+1 in pad modes and F=K in valid-only. After the last pixel of row F-1 -> EMIT.
  - EMIT: in_ready=0, out_valid=1. Streams one output row.
    - End of row with input rows remaining -> ACCEPT.
    - End of row with all IMG_H input rows stored -> stays in EMIT for the next output row.
    - End of the final output row -> DONE.
  - ACCEPT: in_ready=1. Accepts exactly one input row, then -> EMIT.
  - DONE: frame_done=1 for one cycle, then -> IDLE.
- Output rows:
  - Pad modes: r = 0..IMG_H-1. Columns c = -P..IMG_W-1+P, giving IMG_W+2P beats per row.
  - Valid-only: r = P..IMG_H-1-P. Columns c = 0..IMG_W-1.
- Element source coordinates: (r-P+i, c).
  - Out of range in zero-pad: element = 0.
  - Out of range in replicate: row and column are clamped to [0, IMG_H-1] and [0, IMG_W-1].
- Row-r emission begins only after input row min(r+P, IMG_H-1) has been fully stored. A buffer is overwritten only after every output row that needs it has been emitted.
- out_col is registered (1-cycle read latency from the buffers). The first beat of a row appears at most 2 cycles after entering EMIT.
- Stall: while out_valid && !out_ready, out_col, out_first and out_last hold stable. in_valid low in FILL/ACCEPT simply stalls; no pixel is lost or duplicated.
- out_first is high on the beat at the first column; out_last on the beat at the last column. Both are high together only if a row has a single beat, which is illegal given IMG_W >= K.
- Reset asserted in any state returns to IDLE on the next edge, with outputs at reset values. An in-flight frame is discarded.
- in_valid asserted outside FILL/ACCEPT is ignored (in_ready=0).

Test Plan:
- Reset, then idle with in_valid=1 and no start -> in_ready=0, out_valid=0, busy=0 for 10 cycles.
- Replicate, defaults, pixel(y,x)=(y+x) mod 32:
  - first beat (r0, c-1) = {0,0,1} (element0 first), out_first=1;
  - 22 beats per row, 440 beats total;
  - last beat (r19, c20) = {18,19,19} = {(18+19),(19+19),(19+19)} mod 32 = {5,6,6}, out_last=1;
  - frame_done pulses once.
- Zero-pad, same image:
  - beat (r0, c-1) = {0,0,0};
  - beat (r0, c0) = {0,0,1};
  - beat (r5, c3) = {7,8,9};
  - 440 beats total.
- Valid-only, same image:
  - 18 rows x 20 beats = 360 beats;
  - first beat = {0,1,2};
  - last beat (r18, c19) = {36,37,38} mod 32 = {4,5,6}.
- Backpressure: out_ready random 50%, in_valid random 50%, replicate -> beat sequence identical to the unstalled run, and out_col stable during every stall.
- K=5 replicate: first beat (r0, c-2) = {0,0,0,1,2}, 24 beats per row. Reset asserted mid-EMIT of row 7 -> next cycle out_valid=0 and busy=0, and a fresh start runs a complete correct frame.

Source files
------------

// File: rtl/line_window_feeder.sv
// rtl/line_window_feeder.sv - raster pixel stream to K-row window column feeder with border modes
module line_window_feeder #(
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 20,
  parameter int BIT_LENGTH = 5,
  parameter int K          = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [BIT_LENGTH-1:0]   in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [K*BIT_LENGTH-1:0] out_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int P  = (K - 1) / 2;
  localparam int IW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + P + 1) + 1;
  localparam int BW = $clog2(K);

  localparam logic signed [CW-1:0] C_NEG_P   = CW'(-P);
  localparam logic signed [CW-1:0] C_ZERO    = CW'(0);
  localparam logic signed [CW-1:0] C_MAX     = CW'(IMG_W - 1);
  localparam logic signed [CW-1:0] C_PAD_END = CW'(IMG_W - 1 + P);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT, S_ACCEPT, S_DONE} state_t;
  state_t r_state, w_next;

  // Ring of K line buffers; row y lives in buffer y mod K.
  logic [BIT_LENGTH-1:0] r_mem [K][IMG_W];

  logic [1:0]              r_mode;
  logic [IW-1:0]           r_in_col;
  logic [RW-1:0]           r_in_row;
  logic [BW-1:0]           r_wbuf;
  logic signed [CW-1:0]    r_oc;
  logic [RW-1:0]           r_out_row;
  logic [BW-1:0]           r_obuf;
  logic                    r_issuing;
  logic [K*BIT_LENGTH-1:0] r_out_col;
  logic                    r_ov, r_of, r_ol;

  logic                    w_pad, w_zero, w_in_fire, w_out_fire, w_in_row_end;
  logic                    w_row_end, w_load, w_start_row, w_col_oob;
  logic [RW-1:0]           w_fill_last, w_last_row;
  logic signed [CW-1:0]    w_cstart, w_cend;
  logic [IW-1:0]           w_csel;
  logic [K*BIT_LENGTH-1:0] w_col_next;

  assign w_pad        = (r_mode != 2'd0);
  assign w_zero       = (r_mode == 2'd1);
  assign w_fill_last  = w_pad ? RW'(P) : RW'(K - 1);
  assign w_last_row   = w_pad ? RW'(IMG_H - 1) : RW'(IMG_H - 1 - P);
  assign w_cstart     = w_pad ? C_NEG_P : C_ZERO;
  assign w_cend       = w_pad ? C_PAD_END : C_MAX;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = r_ov && out_ready;
  assign w_in_row_end = (r_in_col == IW'(IMG_W - 1));
  assign w_row_end    = w_out_fire && r_ol;
  assign w_load       = r_issuing && (!r_ov || out_ready);
  assign w_start_row  = (w_next == S_EMIT) && ((r_state != S_EMIT) || w_row_end);

  assign out_col   = r_out_col;
  assign out_valid = r_ov;
  assign out_first = r_of;
  assign out_last  = r_ol;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && w_in_row_end && (r_in_row == w_fill_last)) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (w_row_end) begin
          if (r_out_row == w_last_row)        w_next = S_DONE;
          else if (r_in_row < RW'(IMG_H))     w_next = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid && w_in_row_end) w_next = S_EMIT;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Line buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_mem[r_wbuf][r_in_col] <= in_pixel;
  end

  // Column clamp shared by every element of the window column.
  always_comb begin
    w_col_oob = 1'b0;
    w_csel    = r_oc[IW-1:0];
    if (r_oc < C_ZERO) begin
      w_col_oob = 1'b1;
      w_csel    = '0;
    end else if (r_oc > C_MAX) begin
      w_col_oob = 1'b1;
      w_csel    = IW'(IMG_W - 1);
    end
  end

  // Gather one window column: element i comes from row out_row-P+i.
  always_comb begin
    int sr;
    int bi;
    logic zr;
    w_col_next = '0;
    sr = 0;
    bi = 0;
    zr = 1'b0;
    for (int i = 0; i < K; i++) begin
      sr = int'(r_out_row) - P + i;
      zr = w_zero && w_col_oob;
      bi = int'(r_obuf) + i + K - P;
      if (bi >= 2 * K)  bi = bi - 2 * K;
      else if (bi >= K) bi = bi - K;
      if (sr < 0) begin
        zr = w_zero;
        bi = 0;
      end else if (sr > IMG_H - 1) begin
        zr = w_zero;
        bi = (IMG_H - 1) % K;
      end
      w_col_next[i*BIT_LENGTH +: BIT_LENGTH] = zr ? '0 : r_mem[bi[BW-1:0]][w_csel];
    end
  end

  // Counters, ring pointers and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= 2'd0;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_wbuf    <= '0;
      r_oc      <= '0;
      r_out_row <= '0;
      r_obuf    <= '0;
      r_issuing <= 1'b0;
      r_out_col <= '0;
      r_ov      <= 1'b0;
      r_of      <= 1'b0;
      r_ol      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_mode    <= mode;
        r_in_col  <= '0;
        r_in_row  <= '0;
        r_wbuf    <= '0;
        r_out_row <= (mode == 2'd0) ? RW'(P) : '0;
        r_obuf    <= (mode == 2'd0) ? BW'(P) : '0;
        r_issuing <= 1'b0;
      end
      if (w_in_fire) begin
        if (w_in_row_end) begin
          r_in_col <= '0;
          r_in_row <= r_in_row + 1'b1;
          r_wbuf   <= (r_wbuf == BW'(K - 1)) ? '0 : r_wbuf + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (w_load) begin
        r_out_col <= w_col_next;
        r_ov      <= 1'b1;
        r_of      <= (r_oc == w_cstart);
        r_ol      <= (r_oc == w_cend);
        r_oc      <= r_oc + 1'b1;
        if (r_oc == w_cend) r_issuing <= 1'b0;
      end else if (w_out_fire) begin
        r_ov <= 1'b0;
      end
      if (w_row_end && (w_next != S_DONE)) begin
        r_out_row <= r_out_row + 1'b1;
        r_obuf    <= (r_obuf == BW'(K - 1)) ? '0 : r_obuf + 1'b1;
      end
      if (w_start_row) begin
        r_issuing <= 1'b1;
        r_oc      <= w_cstart;
      end
    end
  end
endmodule

// File: tb/tb_line_window_feeder.sv
// tb/tb_line_window_feeder.sv - scoreboard bench for line_window_feeder with K=3 and K=5 instances
module tb_line_window_feeder;
  localparam int W  = 20;
  localparam int H  = 20;
  localparam int BL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, iv, ordy;
  logic [1:0] mode;
  logic [4:0] pix;
  logic       sel;

  logic        ir3, ov3, of3, ol3, fd3, busy3;
  logic [14:0] oc3;
  logic        ir5, ov5, of5, ol5, fd5, busy5;
  logic [24:0] oc5;

  logic        ir, ov, of, ol, fd, busy;
  logic [24:0] oc;

  line_window_feeder #(.IMG_W(W), .IMG_H(H), .BIT_LENGTH(BL), .K(3)) dut3 (
    .clk(clk), .reset(rst), .start(start & ~sel), .mode(mode), .in_pixel(pix),
    .in_valid(iv & ~sel), .in_ready(ir3), .out_col(oc3), .out_valid(ov3),
    .out_ready(ordy & ~sel), .out_first(of3), .out_last(ol3), .frame_done(fd3), .busy(busy3)
  );

  line_window_feeder #(.IMG_W(W), .IMG_H(H), .BIT_LENGTH(BL), .K(5)) dut5 (
    .clk(clk), .reset(rst), .start(start & sel), .mode(mode), .in_pixel(pix),
    .in_valid(iv & sel), .in_ready(ir5), .out_col(oc5), .out_valid(ov5),
    .out_ready(ordy & sel), .out_first(of5), .out_last(ol5), .frame_done(fd5), .busy(busy5)
  );

  assign ir   = sel ? ir5 : ir3;
  assign ov   = sel ? ov5 : ov3;
  assign of   = sel ? of5 : of3;
  assign ol   = sel ? ol5 : ol3;
  assign fd   = sel ? fd5 : fd3;
  assign busy = sel ? busy5 : busy3;
  assign oc   = sel ? oc5 : {10'b0, oc3};

  int n_pass = 0;
  int n_checks = 0;
  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] pixval(int y, int x);
    int t;
    t = (y + x) % 32;
    return t[4:0];
  endfunction

  function automatic logic [24:0] pk(int a, int b, int c, int d, int e);
    logic [24:0] v;
    v = '0;
    v[4:0]   = pixval(a, 0);
    v[9:5]   = pixval(b, 0);
    v[14:10] = pixval(c, 0);
    v[19:15] = pixval(d, 0);
    v[24:20] = pixval(e, 0);
    return v;
  endfunction

  function automatic logic [24:0] model_col(int k, int md, int r, int c);
    logic [24:0] v;
    int p, sr, sc;
    bit z;
    v = '0;
    p = (k - 1) / 2;
    for (int i = 0; i < k; i++) begin
      sr = r - p + i;
      sc = c;
      z  = 1'b0;
      if (sr < 0) begin z = (md == 1); sr = 0; end
      else if (sr > H - 1) begin z = (md == 1); sr = H - 1; end
      if (sc < 0) begin z = z || (md == 1); sc = 0; end
      else if (sc > W - 1) begin z = z || (md == 1); sc = W - 1; end
      v[i*BL +: BL] = z ? 5'd0 : pixval(sr, sc);
    end
    return v;
  endfunction

  task automatic build_expect(input int k, input int md);
    int p, rs, re, cs, ce;
    p  = (k - 1) / 2;
    rs = (md != 0) ? 0 : p;
    re = (md != 0) ? H - 1 : H - 1 - p;
    cs = (md != 0) ? -p : 0;
    ce = (md != 0) ? W - 1 + p : W - 1;
    for (int r = rs; r <= re; r++)
      for (int c = cs; c <= ce; c++)
        exp_q.push_back({(c == cs), (c == ce), model_col(k, md, r, c)});
  endtask

  task automatic run_frame(input int k, input int md, input bit bp, input int abort_at);
    int idx, cyc, fd_cnt, tail, nexp;
    logic [26:0] held, e, g;
    bit stall, rdy, v;
    idx = 0; cyc = 0; fd_cnt = 0; tail = 0; stall = 1'b0; held = '0;
    exp_q.delete();
    got_q.delete();
    build_expect(k, md);
    nexp = exp_q.size();
    @(negedge clk);
    sel   = (k == 5);
    mode  = md[1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 20000) begin
      if (fd) fd_cnt++;
      if (stall) check_eq("stall_hold", {ov, of, ol, oc}, {1'b1, held});
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        ordy = 1'b0;
        iv   = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        check_eq("abort_idle", {30'b0, ov, busy}, 32'b0);
        exp_q.delete();
        return;
      end
      rdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      v    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ordy = rdy;
      iv   = v && (idx < W * H);
      pix  = pixval(idx / W, idx % W);
      stall = ov && !rdy;
      held  = {of, ol, oc};
      if (ov && rdy) begin
        g = {of, ol, oc};
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", {5'b0, g}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", {5'b0, g}, {5'b0, e});
        end
      end
      if (ir && iv) idx++;
      @(negedge clk);
      cyc++;
      if (fd_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
    end
    iv   = 1'b0;
    ordy = 1'b0;
    check_eq("frame_done_pulses", fd_cnt, 1);
    check_eq("beats_total", got_q.size(), nexp);
    check_eq("pixels_consumed", idx, W * H);
    check_eq("busy_after", {31'b0, busy}, 32'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; pix = '0; iv = 1'b0; ordy = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_k3", {26'b0, ir3, ov3, of3, ol3, fd3, busy3}, 32'b0);
    check_eq("reset_k5", {26'b0, ir5, ov5, of5, ol5, fd5, busy5}, 32'b0);
    rst = 1'b0;

    iv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_no_start", {29'b0, ir, ov, busy}, 32'b0);
    end
    iv = 1'b0;

    run_frame(3, 2, 1'b0, -1);
    check_eq("rep_count", got_q.size(), 440);
    if (got_q.size() == 440) begin
      check_eq("rep_first", {5'b0, got_q[0]},   {5'b0, 2'b10, pk(0, 0, 1, 0, 0)});
      check_eq("rep_last",  {5'b0, got_q[439]}, {5'b0, 2'b01, pk(5, 6, 6, 0, 0)});
    end

    run_frame(3, 1, 1'b0, -1);
    check_eq("zero_count", got_q.size(), 440);
    if (got_q.size() == 440) begin
      check_eq("zero_c_m1", {5'b0, got_q[0]},   {5'b0, 2'b10, pk(0, 0, 0, 0, 0)});
      check_eq("zero_c0",   {5'b0, got_q[1]},   {5'b0, 2'b00, pk(0, 0, 1, 0, 0)});
      check_eq("zero_r5c3", {5'b0, got_q[114]}, {5'b0, 2'b00, pk(7, 8, 9, 0, 0)});
    end

    run_frame(3, 0, 1'b0, -1);
    check_eq("valid_count", got_q.size(), 360);
    if (got_q.size() == 360) begin
      check_eq("valid_first", {5'b0, got_q[0]},   {5'b0, 2'b10, pk(0, 1, 2, 0, 0)});
      check_eq("valid_last",  {5'b0, got_q[359]}, {5'b0, 2'b01, pk(4, 5, 6, 0, 0)});
    end

    run_frame(3, 2, 1'b1, -1);
    check_eq("bp_count", got_q.size(), 440);

    run_frame(5, 2, 1'b0, 7 * 24 + 5);
    run_frame(5, 2, 1'b0, -1);
    check_eq("k5_count", got_q.size(), 480);
    if (got_q.size() == 480) begin
      check_eq("k5_first", {5'b0, got_q[0]}, {5'b0, 2'b10, pk(0, 0, 0, 1, 2)});
      check_eq("k5_row_len", {31'b0, got_q[23][25]}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
